// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             diff_bit;
  logic             br_d;
  logic [WIDTH-1:0] sr_d;

  // The single full-subtractor cell operating on the current LSBs.
  assign diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sr_d     = {diff_bit, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          // Results are published only here so d/bout hold through the next RUN.
          if (cnt_q == LAST_BIT) begin
            d_q     <= sr_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one request from IDLE and reports what it observed; callers do the comparing.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bn,
                        output logic [W:0] res, output int busy_cycles,
                        output bit timeout, output bit overlap, output logic done_after);
    @(negedge clk);
    a = av; b = bv; bin = bn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    timeout = 1'b1;
    overlap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    res = {bout, d};
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, bout, d} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b bout=%b d=%h, want all zero", busy, done, bout, d);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    logic [W:0] res; int bc; bit to; bit ov; logic da;
    run_op(4'd9, 4'd3, 1'b0, res, bc, to, ov, da);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout: no done within bound"); end
    checks++;
    if (res !== 5'h06) begin failures++; $display("FAIL basic_result: got %h, want 06", res); end
    checks++;
    if (bc !== W) begin failures++; $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, W); end
    checks++;
    if (ov) begin failures++; $display("FAIL basic_busy_done_overlap: got overlap, want none"); end
    checks++;
    if (da !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got done=%b a cycle later, want 0", da); end
  endtask

  task automatic test_borrow;
    logic [W:0] res; int bc; bit to; bit ov; logic da;
    run_op(4'd3, 4'd9, 1'b0, res, bc, to, ov, da);
    checks++;
    if (to || res !== 5'h1A) begin failures++; $display("FAIL borrow_3_9: got %h timeout=%b, want 1A", res, to); end
    run_op(4'd0, 4'd0, 1'b1, res, bc, to, ov, da);
    checks++;
    if (to || res !== 5'h1F) begin failures++; $display("FAIL borrow_0_0_bin: got %h timeout=%b, want 1F", res, to); end
    run_op(4'd15, 4'd15, 1'b0, res, bc, to, ov, da);
    checks++;
    if (to || res !== 5'h00) begin failures++; $display("FAIL equal_15_15: got %h timeout=%b, want 00", res, to); end
  endtask

  task automatic test_start_held;
    bit to;
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'd1; b = 4'd1;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++;
    if (to || d !== 4'd6 || bout !== 1'b0) begin
      failures++;
      $display("FAIL held_first_result: got d=%h bout=%b timeout=%b, want 6 0", d, bout, to);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL held_after_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL held_second_accept: got busy=%b, want 1", busy); end
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++;
    if (to || d !== 4'd0 || bout !== 1'b0) begin
      failures++;
      $display("FAIL held_second_result: got d=%h bout=%b timeout=%b, want 0 0", d, bout, to);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [W:0] res; int bc; bit to; bit ov; logic da; bit saw_done;
    run_op(4'd9, 4'd3, 1'b0, res, bc, to, ov, da);
    @(negedge clk);
    a = 4'd12; b = 4'd5; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, bout, d} !== 7'b0) begin
      failures++;
      $display("FAIL midrun_reset: got busy=%b done=%b bout=%b d=%h, want all zero", busy, done, bout, d);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin failures++; $display("FAIL midrun_no_done: got activity after reset, want none"); end
    run_op(4'd12, 4'd5, 1'b0, res, bc, to, ov, da);
    checks++;
    if (to || res !== 5'h07) begin failures++; $display("FAIL midrun_fresh: got %h timeout=%b, want 07", res, to); end
  endtask

  task automatic test_hold;
    logic [W:0] res; int bc; bit to; bit ov; logic da; bit moved;
    run_op(4'd9, 4'd3, 1'b0, res, bc, to, ov, da);
    @(negedge clk);
    a = 4'd1; b = 4'd0; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    moved = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin to = 1'b0; break; end
      if (d !== 4'd6) moved = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (moved) begin failures++; $display("FAIL hold_during_run: got d changed before done, want 6 held"); end
    checks++;
    if (to || d !== 4'd1 || bout !== 1'b0) begin
      failures++;
      $display("FAIL hold_result: got d=%h bout=%b timeout=%b, want 1 0", d, bout, to);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int e; logic [W:0] exp_res; int n; bit to; bit first; bit extra;
    @(negedge clk);
    start = 1'b1;
    first = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a = W'(ai); b = W'(bi); bin = ci[0];
          e = ai - bi - ci;
          exp_res = e[W:0];
          to = 1'b1;
          n = 0;
          for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy && done) begin
              checks++; failures++;
              $display("FAIL b2b_overlap: a=%0d b=%0d bin=%0d busy and done both high", ai, bi, ci);
            end
            if (done) begin to = 1'b0; n = i; break; end
          end
          checks++;
          if (to || {bout, d} !== exp_res) begin
            failures++;
            $display("FAIL b2b_result: a=%0d b=%0d bin=%0d got %h timeout=%b, want %h", ai, bi, ci, {bout, d}, to, exp_res);
          end
          checks++;
          if (n !== (first ? W + 1 : W + 2)) begin
            failures++;
            $display("FAIL b2b_interval: a=%0d b=%0d bin=%0d got %0d cycles, want %0d", ai, bi, ci, n, first ? W + 1 : W + 2);
          end
          first = 1'b0;
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    checks++;
    if (extra) begin failures++; $display("FAIL b2b_extra_done: got activity after start dropped, want none"); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_borrow;
    test_start_held;
    test_reset_mid_run;
    test_hold;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
